// File: rtl/dop_packer.sv
// dop_packer: packs left/right 1-bit DSD streams into 16-bit groups, stores
// them as stereo frames in a first-word-fall-through FIFO and presents them as
// 24-bit DoP words {marker, payload} on a valid/ready interface. The marker
// alternates 05/FA per delivered frame.
// Optional build macro: DOP_UNDERRUN_FILL_EN -- once the first frame has been
// delivered, an empty FIFO presents DSD-silence fill frames instead of
// dropping out_valid, and accepted fill frames are counted in underrun_cnt.
`timescale 1ns/1ps

module dop_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             bclk,
    input  logic             rst_n,
    input  logic             dsd_en,
    input  logic             dsd_L,
    input  logic             dsd_R,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [23:0]      out_L,
    output logic [23:0]      out_R,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
`ifdef DOP_UNDERRUN_FILL_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]       MARKER_RST = 8'h05;
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    // Capture side
    logic [3:0]       r_cnt;
    logic [15:0]      r_sh_l;
    logic [15:0]      r_sh_r;
    logic             r_push;

    // FIFO storage and control
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic [7:0]       r_marker;

    logic             w_has_data;
    logic             w_full;
    logic             w_pop;
    logic             w_pop_fifo;
    logic             w_wr;
    logic             w_drop;
    logic [31:0]      w_head;

`ifdef DOP_UNDERRUN_FILL_EN
    logic             r_first_done;
    logic [15:0]      r_underrun;
    logic             w_fill;

    assign w_fill       = r_first_done && !w_has_data;
    assign underrun_cnt = r_underrun;
`endif

    assign w_has_data = (r_level != '0);
    assign w_full     = (r_level == LVL_FULL);
    assign w_pop      = out_valid && out_ready;
    assign w_pop_fifo = w_pop && w_has_data;
    // A completed group is written one cycle after its last capture; while
    // full it only fits if the head leaves in the same cycle.
    assign w_wr       = r_push && (!w_full || w_pop_fifo);
    assign w_drop     = r_push && w_full && !w_pop_fifo;
    assign w_head     = r_mem[r_rd_ptr];

    assign fifo_level = r_level;
    assign overflow   = r_overflow;

    // Shift in one bit per channel on each strobe; flag the push cycle after the 16th bit.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sh_l <= '0;
            r_sh_r <= '0;
            r_push <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            r_push <= dsd_en && (r_cnt == 4'd15);
            if (dsd_en) begin
                r_sh_l <= {r_sh_l[14:0], dsd_L};
                r_sh_r <= {r_sh_r[14:0], dsd_R};
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

    // Frame storage: the shift registers still hold the complete group during the push cycle.
    always_ff @(posedge bclk) begin
        // NOTE: the storage array is deliberately not reset; r_level guards
        // every read, so stale entries are never presented.
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_sh_l, r_sh_r};
        end
    end

    // FIFO pointers, level and the sticky overflow flag.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_fifo) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop_fifo})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Marker flips 05<->FA on every accepted frame.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_marker <= MARKER_RST;
        end else if (w_pop) begin
            r_marker <= ~r_marker;
        end
    end

`ifdef DOP_UNDERRUN_FILL_EN
    // Arm fill after the first real delivery; count accepted fill frames, saturating.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_done <= 1'b0;
            r_underrun   <= '0;
        end else begin
            if (w_pop_fifo) begin
                r_first_done <= 1'b1;
            end
            if (w_pop && !w_has_data && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end
`endif

    // Present the FIFO head (or a fill frame) as DoP words; idle outputs read zero.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        out_valid = w_has_data;
        out_L     = 24'h0;
        out_R     = 24'h0;
        if (w_has_data) begin
            out_L = {r_marker, w_head[31:16]};
            out_R = {r_marker, w_head[15:0]};
        end
`ifdef DOP_UNDERRUN_FILL_EN
        else if (w_fill) begin
            out_valid = 1'b1;
            out_L     = {r_marker, 16'h6969};
            out_R     = {r_marker, 16'h6969};
        end
`endif
    end

endmodule
